// File: rtl/imem_loader.sv
// Streams a length-prefixed, big-endian byte image into instruction memory and
// holds the CPU until every word has been written.
module imem_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wd,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_reg;
    logic [15:0] len_reg;
    logic [15:0] word_cnt_reg;
    logic [1:0]  byte_idx_reg;
    logic [23:0] asm_reg;

    logic                  accept;
    logic [15:0]           len_full;
    logic [15:0]           word_cnt_inc;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign accept       = in_valid && in_ready;
    assign len_full     = {len_reg[15:8], in_data};
    assign word_cnt_inc = word_cnt_reg + 16'd1;
    // Byte address of the word being written; wraps modulo 2^ADDR_WIDTH.
    assign word_addr    = BASE_ADDR + (ADDR_WIDTH'(word_cnt_reg) << 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= LEN_HI;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            byte_idx_reg <= '0;
            asm_reg      <= '0;
            in_ready     <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wd       <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (state_reg)
                LEN_HI: begin
                    if (accept) begin
                        len_reg   <= {in_data, 8'h00};
                        state_reg <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_reg <= len_full;
                        if (len_full == 16'd0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            cpu_hold  <= 1'b0;
                            in_ready  <= 1'b0;
                        end else if ({1'b0, len_full} > MAX_LEN) begin
                            state_reg <= ERROR;
                            error     <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state_reg    <= DATA;
                            byte_idx_reg <= '0;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            state_reg <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_addr;
                            mem_wd    <= {asm_reg, in_data};
                            in_ready  <= 1'b0;
                        end else begin
                            asm_reg <= {asm_reg[15:0], in_data};
                        end
                    end
                end
                WRITE: begin
                    mem_we       <= 1'b0;
                    word_cnt_reg <= word_cnt_inc;
                    if (word_cnt_inc == len_reg) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end else begin
                        state_reg    <= DATA;
                        byte_idx_reg <= '0;
                        in_ready     <= 1'b1;
                    end
                end
                DONE, ERROR: begin
                    if (restart) begin
                        state_reg    <= LEN_HI;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_hold     <= 1'b1;
                        in_ready     <= 1'b1;
                        word_cnt_reg <= '0;
                        byte_idx_reg <= '0;
                        mem_addr     <= BASE_ADDR;
                    end
                end
                default: begin
                    state_reg <= LEN_HI;
                    in_ready  <= 1'b1;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and matched against mem_we strobes of the selected instance.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       restart;

    logic        rdy0, we0, hold0, done0, err0;
    logic [31:0] addr0, wd0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [31:0] addr1, wd1;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(32), .BASE_ADDR(32'd0), .MAX_WORDS(256)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .restart(restart), .mem_we(we0), .mem_addr(addr0),
        .mem_wd(wd0), .cpu_hold(hold0), .done(done0), .error(err0)
    );

    imem_loader #(.ADDR_WIDTH(32), .BASE_ADDR(32'd1024), .MAX_WORDS(3)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .restart(restart), .mem_we(we1), .mem_addr(addr1),
        .mem_wd(wd1), .cpu_hold(hold1), .done(done1), .error(err1)
    );

    int          total = 0;
    int          bad = 0;
    int          writes_seen = 0;
    logic        sel = 1'b0;
    logic [63:0] exp_q[$];

    wire        rdy_s  = sel ? rdy1  : rdy0;
    wire        we_s   = sel ? we1   : we0;
    wire [31:0] addr_s = sel ? addr1 : addr0;
    wire [31:0] wd_s   = sel ? wd1   : wd0;
    wire        hold_s = sel ? hold1 : hold0;
    wire        done_s = sel ? done1 : done0;
    wire        err_s  = sel ? err1  : err0;

    // Scoreboard side: every write strobe must match the head of the queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && we_s) begin
            writes_seen++;
            total++;
            $display("write dut%0d addr=%0d data=%08h", sel, addr_s, wd_s);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got addr=%0d data=%08h want none", addr_s, wd_s);
            end else begin
                e = exp_q.pop_front();
                if ({addr_s, wd_s} !== e) begin
                    bad++;
                    $display("FAIL write_match got %08h_%08h want %08h", addr_s, wd_s, e);
                end
            end
            total++;
            if (rdy_s !== 1'b0) begin
                bad++;
                $display("FAIL ready_in_write got %b want 0", rdy_s);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int budget = 40;
        in_data  = b;
        in_valid = 1'b1;
        while (rdy_s !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            total++;
            bad++;
            $display("FAIL send_timeout got ready=%b want 1", rdy_s);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] a);
        exp_q.push_back({a, w});
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic do_reset(input logic which);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        reset    = 1'b1;
        sel      = which;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        writes_seen = 0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        total += 7;
        if (rdy_s !== 1'b1)   begin bad++; $display("FAIL rst_ready got %b want 1", rdy_s); end
        if (we_s !== 1'b0)    begin bad++; $display("FAIL rst_we got %b want 0", we_s); end
        if (addr_s !== 32'd0) begin bad++; $display("FAIL rst_addr got %0d want 0", addr_s); end
        if (wd_s !== 32'd0)   begin bad++; $display("FAIL rst_wd got %08h want 0", wd_s); end
        if (hold_s !== 1'b1)  begin bad++; $display("FAIL rst_hold got %b want 1", hold_s); end
        if (done_s !== 1'b0)  begin bad++; $display("FAIL rst_done got %b want 0", done_s); end
        if (err_s !== 1'b0)   begin bad++; $display("FAIL rst_error got %b want 0", err_s); end
    endtask

    task automatic test_two_words();
        do_reset(1'b0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h20010005, 32'd0);
        send_word(32'h20020007, 32'd4);
        total += 2;
        if (done_s !== 1'b0) begin bad++; $display("FAIL two_done_early got %b want 0", done_s); end
        if (hold_s !== 1'b1) begin bad++; $display("FAIL two_hold_early got %b want 1", hold_s); end
        @(negedge clk);
        in_valid = 1'b0;
        total += 5;
        if (done_s !== 1'b1) begin bad++; $display("FAIL two_done got %b want 1", done_s); end
        if (hold_s !== 1'b0) begin bad++; $display("FAIL two_hold got %b want 0", hold_s); end
        if (rdy_s !== 1'b0)  begin bad++; $display("FAIL two_ready got %b want 0", rdy_s); end
        if (writes_seen !== 2) begin bad++; $display("FAIL two_count got %0d want 2", writes_seen); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL two_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_zero_len();
        do_reset(1'b0);
        send_byte(8'h00);
        send_byte(8'h00);
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        total += 3;
        if (done_s !== 1'b1) begin bad++; $display("FAIL zero_done got %b want 1", done_s); end
        if (hold_s !== 1'b0) begin bad++; $display("FAIL zero_hold got %b want 0", hold_s); end
        if (writes_seen !== 0) begin bad++; $display("FAIL zero_writes got %0d want 0", writes_seen); end
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        send_byte(8'h01);
        send_byte(8'h01);
        in_data = 8'h77;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        total += 5;
        if (err_s !== 1'b1)  begin bad++; $display("FAIL ovf_error got %b want 1", err_s); end
        if (hold_s !== 1'b1) begin bad++; $display("FAIL ovf_hold got %b want 1", hold_s); end
        if (rdy_s !== 1'b0)  begin bad++; $display("FAIL ovf_ready got %b want 0", rdy_s); end
        if (done_s !== 1'b0) begin bad++; $display("FAIL ovf_done got %b want 0", done_s); end
        if (writes_seen !== 0) begin bad++; $display("FAIL ovf_writes got %0d want 0", writes_seen); end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total += 3;
        if (err_s !== 1'b0)  begin bad++; $display("FAIL rst_pulse_error got %b want 0", err_s); end
        if (rdy_s !== 1'b1)  begin bad++; $display("FAIL rst_pulse_ready got %b want 1", rdy_s); end
        if (hold_s !== 1'b1) begin bad++; $display("FAIL rst_pulse_hold got %b want 1", hold_s); end
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h12345678, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        total += 2;
        if (done_s !== 1'b1) begin bad++; $display("FAIL reload_done got %b want 1", done_s); end
        if (writes_seen !== 1) begin bad++; $display("FAIL reload_count got %0d want 1", writes_seen); end
    endtask

    task automatic test_gapped();
        logic [7:0] bytes [6];
        bytes = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_reset(1'b0);
        exp_q.push_back({32'd0, 32'hAABBCCDD});
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[i]);
            in_valid = 1'b0;
            in_data  = 8'hEE;
            if (i != 5) repeat (2) @(negedge clk);
        end
        @(negedge clk);
        total += 3;
        if (done_s !== 1'b1) begin bad++; $display("FAIL gap_done got %b want 1", done_s); end
        if (writes_seen !== 1) begin bad++; $display("FAIL gap_count got %0d want 1", writes_seen); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL gap_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midword();
        do_reset(1'b0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h11223344, 32'd0);
        send_byte(8'h55);
        send_byte(8'h66);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        total += 6;
        if (we_s !== 1'b0)    begin bad++; $display("FAIL async_we got %b want 0", we_s); end
        if (rdy_s !== 1'b1)   begin bad++; $display("FAIL async_ready got %b want 1", rdy_s); end
        if (wd_s !== 32'd0)   begin bad++; $display("FAIL async_wd got %08h want 0", wd_s); end
        if (addr_s !== 32'd0) begin bad++; $display("FAIL async_addr got %0d want 0", addr_s); end
        if (hold_s !== 1'b1)  begin bad++; $display("FAIL async_hold got %b want 1", hold_s); end
        if (writes_seen !== 1) begin bad++; $display("FAIL async_count got %0d want 1", writes_seen); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hCAFEF00D, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        total += 2;
        if (done_s !== 1'b1) begin bad++; $display("FAIL async_reload_done got %b want 1", done_s); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL async_pending got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_base_addr();
        do_reset(1'b1);
        total++;
        if (addr_s !== 32'd1024) begin bad++; $display("FAIL base_rst_addr got %0d want 1024", addr_s); end
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(32'h01020304, 32'd1024);
        exp_q.push_back({32'd1028, 32'hA5A55A5A});
        send_byte(8'hA5);
        send_byte(8'hA5);
        in_valid = 1'b0;
        restart  = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total++;
        if (hold_s !== 1'b1) begin bad++; $display("FAIL base_restart_hold got %b want 1", hold_s); end
        send_byte(8'h5A);
        send_byte(8'h5A);
        send_word(32'hDEADBEEF, 32'd1032);
        @(negedge clk);
        in_valid = 1'b0;
        total += 3;
        if (done_s !== 1'b1) begin bad++; $display("FAIL base_done got %b want 1", done_s); end
        if (writes_seen !== 3) begin bad++; $display("FAIL base_count got %0d want 3", writes_seen); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL base_pending got %0d want 0", exp_q.size()); end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        send_byte(8'h00);
        send_byte(8'h04);
        in_valid = 1'b0;
        total += 2;
        if (err_s !== 1'b1)  begin bad++; $display("FAIL base_over_error got %b want 1", err_s); end
        if (hold_s !== 1'b1) begin bad++; $display("FAIL base_over_hold got %b want 1", hold_s); end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        test_reset();
        test_two_words();
        test_zero_len();
        test_overflow();
        test_gapped();
        test_reset_midword();
        test_base_addr();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
